// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - SRAM-like request/response bundle shared by fetch, memory and downstream ports
interface sram_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Requester side: issues the request, receives the handshakes and read data
  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Responder side: accepts the request, returns the handshakes and read data
  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-source SRAM-like arbiter with in-order ID FIFO; SRAM_ARB_RR_EN selects round-robin ties
module sram_arbiter #(
  parameter int OT_DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  sram_arbiter_if.slave  inst_if,
  sram_arbiter_if.slave  data_if,
  sram_arbiter_if.master mem_if,
  output logic           arb_err_o
);

  localparam int PW = $clog2(OT_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(OT_DEPTH);

  // ID storage: 0 = inst, 1 = data
  logic [OT_DEPTH-1:0] id_q;
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [PW:0]         count_q;
  logic [PW:0]         count_d;
  logic                lock_q;
  logic                lock_src_q;
  logic                arb_err_q;
`ifdef SRAM_ARB_RR_EN
  logic                last_grant_q;
`endif

  logic gnt_inst;
  logic gnt_data;
  logic lock_hit;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_id;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign head_id = id_q[rd_ptr_q];

  // Grant selection: a held lock wins while its source still requests, then tie-break, then lone requester
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    lock_hit = lock_q & (lock_src_q ? data_if.req : inst_if.req);
    if (lock_hit) begin
      gnt_data = lock_src_q;
      gnt_inst = ~lock_src_q;
    end else if (inst_if.req & data_if.req) begin
`ifdef SRAM_ARB_RR_EN
      gnt_inst = last_grant_q;
      gnt_data = ~last_grant_q;
`else
      gnt_data = 1'b1;
`endif
    end else begin
      gnt_inst = inst_if.req;
      gnt_data = data_if.req;
    end
  end

  // Downstream request fields follow the granted source, zero when nobody is granted
  always_comb begin
    mem_if.wr    = 1'b0;
    mem_if.size  = 2'b0;
    mem_if.wstrb = 4'b0;
    mem_if.addr  = 32'b0;
    mem_if.wdata = 32'b0;
    if (gnt_inst) begin
      mem_if.wr    = inst_if.wr;
      mem_if.size  = inst_if.size;
      mem_if.wstrb = inst_if.wstrb;
      mem_if.addr  = inst_if.addr;
      mem_if.wdata = inst_if.wdata;
    end else if (gnt_data) begin
      mem_if.wr    = data_if.wr;
      mem_if.size  = data_if.size;
      mem_if.wstrb = data_if.wstrb;
      mem_if.addr  = data_if.addr;
      mem_if.wdata = data_if.wdata;
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never re-opens the request path
  assign mem_if.req      = (inst_if.req | data_if.req) & ~full & ~reset_i;
  assign push            = mem_if.req & mem_if.addr_ok;
  assign pop             = mem_if.data_ok & ~empty & ~reset_i;

  assign inst_if.addr_ok = mem_if.addr_ok & mem_if.req & gnt_inst;
  assign data_if.addr_ok = mem_if.addr_ok & mem_if.req & gnt_data;
  assign inst_if.data_ok = pop & ~head_id;
  assign data_if.data_ok = pop & head_id;
  assign inst_if.rdata   = mem_if.rdata;
  assign data_if.rdata   = mem_if.rdata;
  assign arb_err_o       = arb_err_q;

  // Occupancy change from the push/pop pair; both together leave it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // In-order ID FIFO: push the granted source on address handshake, pop the head on data return
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= gnt_data;
        wr_ptr_q       <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // Hold the grant on a source whose request was presented but not accepted
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
    end else begin
      lock_q     <= mem_if.req & ~mem_if.addr_ok;
      lock_src_q <= gnt_data;
    end
  end

  // Sticky error: data returned with nothing outstanding
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      arb_err_q <= 1'b0;
    end else if (mem_if.data_ok & empty) begin
      arb_err_q <= 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Remember who won the last accepted request so ties alternate
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= 1'b1;
    end else if (push) begin
      last_grant_q <= gnt_data;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized bench for sram_arbiter against a queue-based reference model
module tb_sram_arbiter;
  localparam int OT = 4;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic arb_err;
  always #5 clk = ~clk;

  sram_arbiter_if inst_bus ();
  sram_arbiter_if data_bus ();
  sram_arbiter_if mem_bus ();

  sram_arbiter #(.OT_DEPTH(OT)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .inst_if  (inst_bus),
    .data_if  (data_bus),
    .mem_if   (mem_bus),
    .arb_err_o(arb_err)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int q[$];
  int held = -1;
  int last = 1;
  bit err_m = 1'b0;

  // last observed values for directed checks
  logic        obs_mreq, obs_iaok, obs_daok, obs_idok, obs_ddok, obs_err;
  logic [31:0] obs_addr;
  logic [31:0] last_daddr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ireq, input bit dreq, input bit aok,
                      input bit dok, input logic [31:0] iaddr);
    int g;
    bit mreq, push, pop;
    logic [38:0] efld;
    logic [31:0] eaddr;
    @(negedge clk);
    reset            = rst;
    inst_bus.req     = ireq;
    inst_bus.wr      = 1'($urandom);
    inst_bus.size    = 2'($urandom);
    inst_bus.wstrb   = 4'($urandom);
    inst_bus.addr    = iaddr;
    inst_bus.wdata   = $urandom;
    data_bus.req     = dreq;
    data_bus.wr      = 1'($urandom);
    data_bus.size    = 2'($urandom);
    data_bus.wstrb   = 4'($urandom);
    data_bus.addr    = $urandom;
    data_bus.wdata   = $urandom;
    mem_bus.addr_ok  = aok;
    mem_bus.data_ok  = dok;
    mem_bus.rdata    = $urandom;
    last_daddr       = data_bus.addr;
    #2;
    if (!ireq && !dreq) g = -1;
    else if (held >= 0 && ((held == 0) ? ireq : dreq)) g = held;
    else if (ireq && dreq) g = RR ? 1 - last : 1;
    else g = ireq ? 0 : 1;
    mreq = (ireq || dreq) && (q.size() < OT) && !rst;
    push = mreq && aok;
    pop  = dok && (q.size() > 0) && !rst;
    if (g == 0) begin
      eaddr = inst_bus.addr;
      efld  = {inst_bus.wr, inst_bus.size, inst_bus.wstrb, inst_bus.wdata};
    end else if (g == 1) begin
      eaddr = data_bus.addr;
      efld  = {data_bus.wr, data_bus.size, data_bus.wstrb, data_bus.wdata};
    end else begin
      eaddr = 32'h0;
      efld  = '0;
    end
    check_val("mem_req", mem_bus.req, mreq);
    check_val("mem_addr", mem_bus.addr, eaddr);
    check_val("mem_wdata", mem_bus.wdata, efld[31:0]);
    check_val("mem_ctl", {mem_bus.wr, mem_bus.size, mem_bus.wstrb}, efld[38:32]);
    check_val("inst_addr_ok", inst_bus.addr_ok, push && g == 0);
    check_val("data_addr_ok", data_bus.addr_ok, push && g == 1);
    check_val("inst_data_ok", inst_bus.data_ok, pop && q[0] == 0);
    check_val("data_data_ok", data_bus.data_ok, pop && q[0] == 1);
    check_val("inst_rdata", inst_bus.rdata, mem_bus.rdata);
    check_val("data_rdata", data_bus.rdata, mem_bus.rdata);
    check_val("arb_err", arb_err, err_m);
    obs_mreq = mem_bus.req;
    obs_iaok = inst_bus.addr_ok;
    obs_daok = data_bus.addr_ok;
    obs_idok = inst_bus.data_ok;
    obs_ddok = data_bus.data_ok;
    obs_err  = arb_err;
    obs_addr = mem_bus.addr;
    @(posedge clk);
    if (rst) begin
      q.delete();
      held  = -1;
      last  = 1;
      err_m = 1'b0;
    end else begin
      if (dok && q.size() == 0) err_m = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(g);
        last = g;
      end
      held = (mreq && !aok) ? g : -1;
    end
  endtask

  initial begin
    reset = 1'b1;
    step(1, 0, 0, 0, 0, $urandom);
    step(1, 1, 1, 1, 1, $urandom);
    check_val("rst_mem_req", obs_mreq, 1'b0);
    check_val("rst_data_ok", {obs_idok, obs_ddok}, 2'b00);

    // first fetch accepted in the same cycle
    step(0, 1, 0, 1, 0, 32'hbfc00000);
    check_val("boot_addr_ok", obs_iaok, 1'b1);
    check_val("boot_addr", obs_addr, 32'hbfc00000);
    step(0, 0, 0, 0, 1, $urandom);
    check_val("boot_data_ok", obs_idok, 1'b1);

    // tie handling from a fresh reset
    step(1, 0, 0, 0, 0, $urandom);
    step(0, 1, 1, 1, 0, $urandom);
    check_val("tie1_inst", obs_iaok, RR);
    check_val("tie1_data", obs_daok, !RR);
    step(0, 1, 1, 1, 0, $urandom);
    check_val("tie2_data", obs_daok, 1'b1);
    step(0, 0, 0, 0, 1, $urandom);
    check_val("tie_ret1", {obs_idok, obs_ddok}, RR ? 2'b10 : 2'b01);
    step(0, 0, 0, 0, 1, $urandom);
    check_val("tie_ret2", {obs_idok, obs_ddok}, 2'b01);

    // lock held on data while inst also requests
    step(0, 0, 1, 0, 0, $urandom);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, $urandom);
      check_val("lock_no_iaok", obs_iaok, 1'b0);
      check_val("lock_addr", obs_addr, last_daddr);
    end
    step(0, 1, 1, 1, 0, $urandom);
    check_val("lock_accept", obs_daok, 1'b1);
    step(0, 0, 0, 0, 1, $urandom);

    // full FIFO blocks even with a same-cycle return
    step(1, 0, 0, 0, 0, $urandom);
    for (int i = 0; i < OT; i++) step(0, 1, 0, 1, 0, $urandom);
    step(0, 1, 0, 1, 1, $urandom);
    check_val("full_block", obs_mreq, 1'b0);
    check_val("full_pop", obs_idok, 1'b1);
    step(0, 1, 0, 1, 0, $urandom);
    check_val("full_reopen", obs_mreq, 1'b1);

    // stray data return
    step(1, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 1, $urandom);
    check_val("stray_ok", {obs_idok, obs_ddok}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, $urandom);
      check_val("err_sticky", obs_err, 1'b1);
    end
    step(1, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, $urandom);
    check_val("err_clear", obs_err, 1'b0);

    // reset discards outstanding IDs
    step(0, 1, 0, 1, 0, $urandom);
    step(0, 0, 1, 1, 0, $urandom);
    step(1, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 1, $urandom);
    check_val("post_rst_ok", {obs_idok, obs_ddok}, 2'b00);
    step(0, 0, 0, 0, 0, $urandom);
    check_val("post_rst_err", obs_err, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 60), ($urandom_range(99) < 60),
           ($urandom_range(99) < 60), ($urandom_range(99) < 35), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter OT_DEPTH, default 4, sets the maximum outstanding memory transactions; it SHALL be a power of 2 and at least 2.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst_req/inst_wr/inst_size/inst_wstrb/inst_addr/inst_wdata  in  1/1/2/4/32/32  SRAM-like request from the fetch stage.
REQ-005 inst_addr_ok/inst_data_ok  out  1/1, and inst_rdata  out  32  SRAM-like response to the fetch stage.
REQ-006 data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata  in  1/1/2/4/32/32  SRAM-like request from the memory stage.
REQ-007 data_addr_ok/data_data_ok  out  1/1, and data_rdata  out  32  SRAM-like response to the memory stage.
REQ-008 mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata  out  1/1/2/4/32/32  shared downstream SRAM-like request.
REQ-009 mem_addr_ok/mem_data_ok  in  1/1, and mem_rdata  in  32  shared downstream response.
REQ-010 arb_err  out  1  sticky flag: mem_data_ok arrived with no transaction outstanding.

Function
REQ-011 Grant SHALL be combinational each cycle: gnt_inst or gnt_data, at most one of them high.
REQ-012 mem_req SHALL be high only when (inst_req | data_req) is high and the ID FIFO is not full; a same-cycle pop SHALL NOT lift the full condition.
REQ-013 mem_wr/size/wstrb/addr/wdata SHALL be a mux of the granted requester's fields; when no grant is active they SHALL be 0.
REQ-014 inst_addr_ok SHALL equal mem_addr_ok & mem_req & gnt_inst; data_addr_ok SHALL follow the same rule with gnt_data.
REQ-015 Lock: if mem_req & !mem_addr_ok in a cycle, the grant SHALL stay on the same source next cycle while that source's req stays high; if that req drops, the lock SHALL release in the same cycle.
REQ-016 Handshake push: on mem_req & mem_addr_ok, the granted source ID (0=inst, 1=data) SHALL be pushed into an in-order FIFO of depth OT_DEPTH.
REQ-017 Handshake pop: on mem_data_ok with the FIFO non-empty, the head SHALL be popped and the matching *_data_ok driven high for that cycle only; zero-cycle latency from mem_data_ok.
REQ-018 inst_rdata and data_rdata SHALL both carry mem_rdata at all times; consumers qualify it with their own data_ok.
REQ-019 Push and pop in the same cycle SHALL both take effect and leave the count unchanged.
REQ-020 FIFO pointers SHALL be log2(OT_DEPTH) bits and wrap modulo OT_DEPTH.
REQ-021 The count SHALL be log2(OT_DEPTH)+1 bits; full is count==OT_DEPTH and empty is count==0.
REQ-022 mem_data_ok while the FIFO is empty SHALL assert no *_data_ok, leave the FIFO unchanged and set arb_err.
REQ-023 Data flows strictly in order: a response SHALL never be routed to a source other than the FIFO head.

Reset
REQ-024 While reset is high, the FIFO SHALL empty (pointers and count to 0), the lock SHALL clear, last_grant SHALL be set to DATA and arb_err SHALL clear.
REQ-025 During reset, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL discard all outstanding IDs; a mem_data_ok arriving after reset with an empty FIFO falls under REQ-022.

Configuration
REQ-027 Macro SRAM_ARB_RR_EN defined: an unlocked tie SHALL be granted round-robin to the source opposite last_grant, and last_grant SHALL update on every push.
REQ-028 SRAM_ARB_RR_EN undefined: an unlocked tie SHALL always grant data, and the last_grant register SHALL be absent.
REQ-029 With either setting, a lone requester SHALL be granted immediately, subject to REQ-012 and REQ-015.

Verification
REQ-030 Reset, then inst_req with addr 0xbfc00000 and mem_addr_ok=1 -> inst_addr_ok=1 and mem_addr=0xbfc00000 in that cycle; count=1.
REQ-031 Simultaneous inst/data requests with mem_addr_ok=1 for 2 cycles -> RR build grants inst then data; non-RR build grants data then data; the data_ok sequence matches the push order.
REQ-032 data_req with mem_addr_ok=0 for 3 cycles while inst_req is also high -> grant held on data all 3 cycles; no inst_addr_ok.
REQ-033 OT_DEPTH=4: 4 accepted requests with no mem_data_ok -> mem_req=0 in the 5th cycle even with mem_data_ok=1 that cycle; mem_req=1 the next cycle.
REQ-034 mem_data_ok=1 with the FIFO empty -> inst_data_ok=0, data_data_ok=0, arb_err=1 until reset.
REQ-035 Reset asserted with 2 IDs outstanding -> count=0 the next cycle; the following mem_data_ok sets arb_err.
